// File: rtl/arb_pkg.sv
// Shared definitions for the four-way round-robin arbiter: sizes, the
// FSM state encoding and the owner-index to one-hot grant decode.
package arb_pkg;

  localparam int NUM_REQ = 4;
  localparam int IDX_W   = 2;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  // Binary owner index to one-hot grant pattern.
  function automatic logic [NUM_REQ-1:0] idx_to_onehot(input logic [IDX_W-1:0] idx);
    return NUM_REQ'(1) << idx;
  endfunction

endpackage

// File: rtl/gnt_decoder.sv
// Combinational 2-to-4 one-hot decode of the next owner index; the FSM
// registers the result into the grant vector.
module gnt_decoder
  import arb_pkg::*;
(
  input  logic [IDX_W-1:0]   idx,
  output logic [NUM_REQ-1:0] onehot
);

  assign onehot = idx_to_onehot(idx);

endmodule

// File: rtl/rr_arbiter4.sv
// Four-requester round-robin arbiter. A registered FSM grants one owner
// and holds the grant until that owner drops its request; one dead cycle
// always separates consecutive owners.
// Optional feature macro: ARB_TIMEOUT_EN -- revokes a grant held for
// TIMEOUT_CYCLES while others wait, pulsing expired for one cycle.
module rr_arbiter4
  import arb_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16,
  parameter int CNT_W          = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] req,
  output logic [NUM_REQ-1:0] gnt,
  output logic [IDX_W-1:0]   gnt_idx,
  output logic               busy,
  output logic               expired
);

  // Reject parameter combinations the hold counter cannot represent.
  if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 255 || (1 << CNT_W) <= TIMEOUT_CYCLES) begin : g_bad_param
    $error("rr_arbiter4: illegal TIMEOUT_CYCLES/CNT_W combination");
  end

  state_t             state;
  logic [IDX_W-1:0]   last;
  logic [IDX_W-1:0]   win_idx;
  logic               win_vld;
  logic [IDX_W-1:0]   cand;
  logic [NUM_REQ-1:0] win_onehot;

  // Rotating priority search: last+1, last+2, last+3, then last itself.
  always_comb begin
    win_idx = last;
    win_vld = 1'b0;
    cand    = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = last + IDX_W'(k);
      if (!win_vld && req[cand]) begin
        win_idx = cand;
        win_vld = 1'b1;
      end
    end
  end

  gnt_decoder u_dec (
    .idx    (win_idx),
    .onehot (win_onehot)
  );

`ifdef ARB_TIMEOUT_EN
  logic [CNT_W-1:0] cnt;
  logic             others;
  logic             at_limit;

  assign others   = |(req & ~gnt);
  assign at_limit = (cnt == CNT_W'(TIMEOUT_CYCLES - 1));

  // Arbitration FSM with hold counter; a timed-out owner keeps last, so it
  // naturally gets lowest priority at the next arbitration.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      last    <= IDX_W'(NUM_REQ - 1);
      gnt     <= '0;
      gnt_idx <= '0;
      busy    <= 1'b0;
      expired <= 1'b0;
      cnt     <= '0;
    end else begin
      expired <= 1'b0;
      case (state)
        IDLE: begin
          if (win_vld) begin
            state   <= BUSY;
            gnt     <= win_onehot;
            gnt_idx <= win_idx;
            last    <= win_idx;
            busy    <= 1'b1;
            cnt     <= '0;
          end
        end
        BUSY: begin
          if (!req[gnt_idx]) begin
            state <= IDLE;
            gnt   <= '0;
            busy  <= 1'b0;
          end else if (at_limit && others) begin
            state   <= IDLE;
            gnt     <= '0;
            busy    <= 1'b0;
            expired <= 1'b1;
          end else if (!at_limit) begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: begin
          state <= IDLE;
          gnt   <= '0;
          busy  <= 1'b0;
        end
      endcase
    end
  end
`else
  assign expired = 1'b0;

  // Arbitration FSM: grant the search winner, hold until the owner releases.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      last    <= IDX_W'(NUM_REQ - 1);
      gnt     <= '0;
      gnt_idx <= '0;
      busy    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (win_vld) begin
            state   <= BUSY;
            gnt     <= win_onehot;
            gnt_idx <= win_idx;
            last    <= win_idx;
            busy    <= 1'b1;
          end
        end
        BUSY: begin
          if (!req[gnt_idx]) begin
            state <= IDLE;
            gnt   <= '0;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          gnt   <= '0;
          busy  <= 1'b0;
        end
      endcase
    end
  end
`endif

endmodule
